// File: rtl/sram_dma_pkg.sv
// sram_dma_pkg: shared constants, register map and FSM states
// for the SRAM bank arbiter / DMA engine.
package sram_dma_pkg;

   localparam int BANK_AW = 9;
   localparam int BANKS   = 8;
   localparam int BANK_W  = $clog2(BANKS);
   localparam int ADDR_W  = BANK_AW + BANK_W;

   localparam logic [2:0] REG_SRC_LO = 3'd0;
   localparam logic [2:0] REG_SRC_HI = 3'd1;
   localparam logic [2:0] REG_DST_LO = 3'd2;
   localparam logic [2:0] REG_DST_HI = 3'd3;
   localparam logic [2:0] REG_LEN_LO = 3'd4;
   localparam logic [2:0] REG_LEN_HI = 3'd5;
   localparam logic [2:0] REG_CTRL   = 3'd6;
   localparam logic [2:0] REG_FILL   = 3'd7;

   localparam int CTRL_START    = 0;
   localparam int CTRL_FILL     = 1;
   localparam int CTRL_IRQ_EN   = 2;
   localparam int CTRL_ABORT    = 3;
   localparam int CTRL_DONE_CLR = 4;

   localparam int ST_BUSY   = 0;
   localparam int ST_DONE   = 1;
   localparam int ST_IRQ_EN = 2;
   localparam int ST_FILL   = 3;

   typedef enum logic [2:0] {
      IDLE, RD, CAP, WR, FILLWR, DONE
   } state_t;

endpackage

// File: rtl/sram_dma_regfile.sv
// sram_dma_regfile: bus decode, DMA config registers, STATUS mux
// and DONE/irq flag. FILL support under SRAM_DMA_FILL_EN.
module sram_dma_regfile
   import sram_dma_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst,
   input  logic [2:0]        addr,
   input  logic [7:0]        data_in,
   input  logic              bus_cyc,
   input  logic              bus_we,
   input  logic              busy,
   input  logic              done_set,
   output logic [7:0]        data_out,
   output logic              irq_o,
   output logic [ADDR_W-1:0] src,
   output logic [ADDR_W-1:0] dst,
   output logic [ADDR_W-1:0] len,
   output logic [7:0]        fill,
   output logic              fill_mode,
   output logic              start,
   output logic              abort
);

   logic wr;
   logic ctrl_wr;
   logic done;
   logic irq_en;

   assign wr      = bus_cyc & bus_we;
   assign ctrl_wr = wr & (addr == REG_CTRL);
   assign abort   = ctrl_wr & data_in[CTRL_ABORT];
   assign start   = ctrl_wr & data_in[CTRL_START]
                  & ~data_in[CTRL_ABORT] & ~busy;
   assign irq_o   = done & irq_en;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         irq_en <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (wr & ~busy) begin
            unique case (1'b1)
               (addr == REG_SRC_LO): src[7:0]  <= data_in;
               (addr == REG_SRC_HI): src[11:8] <= data_in[3:0];
               (addr == REG_DST_LO): dst[7:0]  <= data_in;
               (addr == REG_DST_HI): dst[11:8] <= data_in[3:0];
               (addr == REG_LEN_LO): len[7:0]  <= data_in;
               (addr == REG_LEN_HI): len[11:8] <= data_in[3:0];
               default: ;
            endcase
         end
         if (ctrl_wr)
            irq_en <= data_in[CTRL_IRQ_EN];
         // a zero-length START clears and re-sets in one cycle
         if (done_set)
            done <= 1'b1;
         else if (start | (ctrl_wr & data_in[CTRL_DONE_CLR]))
            done <= 1'b0;
      end
   end

`ifdef SRAM_DMA_FILL_EN
   always_ff @(posedge clk_i) begin
      if (rst) begin
         fill      <= '0;
         fill_mode <= 1'b0;
      end else begin
         if (wr & ~busy & (addr == REG_FILL))
            fill <= data_in;
         if (ctrl_wr & ~busy)
            fill_mode <= data_in[CTRL_FILL];
      end
   end
`else
   assign fill      = '0;
   assign fill_mode = 1'b0;
`endif

   always_comb begin
      data_out = '0;
      case (addr)
         REG_SRC_LO: data_out = src[7:0];
         REG_SRC_HI: data_out = {4'h0, src[11:8]};
         REG_DST_LO: data_out = dst[7:0];
         REG_DST_HI: data_out = {4'h0, dst[11:8]};
         REG_LEN_LO: data_out = len[7:0];
         REG_LEN_HI: data_out = {4'h0, len[11:8]};
         REG_CTRL: begin
            data_out[ST_BUSY]   = busy;
            data_out[ST_DONE]   = done;
            data_out[ST_IRQ_EN] = irq_en;
            data_out[ST_FILL]   = fill_mode;
         end
         default: data_out = fill;
      endcase
   end

endmodule

// File: rtl/sram_dma_ctrl.sv
// sram_dma_ctrl: CPU/DMA arbiter for the 8-bank SRAM array, DMA FSM,
// counters and SRAM drive. Fill mode enabled by SRAM_DMA_FILL_EN.
module sram_dma_ctrl
   import sram_dma_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [7:0]          cpu_wdata,
   output logic [7:0]          cpu_rdata,
   output logic                cpu_ack,
   input  logic [2:0]          addr,
   input  logic [7:0]          data_in,
   output logic [7:0]          data_out,
   input  logic                bus_cyc,
   input  logic                bus_we,
   output logic                irq_o,
   output logic                CEN,
   output logic [7:0]          WEN,
   output logic [BANK_AW-1:0]  A,
   output logic [7:0]          D,
   output logic [BANKS-1:0]    GWEN,
   input  logic [8*BANKS-1:0]  Q
);

   state_t state, next_state;

   logic [ADDR_W-1:0] src, dst, len;
   logic [ADDR_W-1:0] src_cnt, dst_cnt, cnt;
   logic [ADDR_W-1:0] acc_addr;
   logic [7:0]        fill, hold, q_sel, acc_data;
   logic [BANK_W-1:0] rd_bank;
   logic fill_mode, start, abort, busy, done_set;
   logic cpu_gnt, dma_free, dma_rd, dma_wr;
   logic acc, acc_we, ack_rd;

   sram_dma_regfile u_regs (
      .clk_i     (clk_i),
      .rst       (rst),
      .addr      (addr),
      .data_in   (data_in),
      .bus_cyc   (bus_cyc),
      .bus_we    (bus_we),
      .busy      (busy),
      .done_set  (done_set),
      .data_out  (data_out),
      .irq_o     (irq_o),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .fill      (fill),
      .fill_mode (fill_mode),
      .start     (start),
      .abort     (abort)
   );

   assign busy     = (state != IDLE) && (state != DONE);
   assign cpu_gnt  = cpu_req & ~rst;
   assign dma_free = ~cpu_req & ~abort & ~rst;
   assign dma_rd   = (state == RD) & dma_free;
   assign dma_wr   = ((state == WR) | (state == FILLWR)) & dma_free;
   assign done_set = (next_state == DONE);

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, DONE: begin
            next_state = IDLE;
            if (start) begin
               if (len == '0)
                  next_state = DONE;
               else
                  next_state = fill_mode ? FILLWR : RD;
            end
         end
         RD: begin
            if (abort)
               next_state = IDLE;
            else if (dma_rd)
               next_state = CAP;
         end
         CAP: next_state = abort ? IDLE : WR;
         WR, FILLWR: begin
            if (abort)
               next_state = IDLE;
            else if (dma_wr) begin
               if (cnt == 12'd1)
                  next_state = DONE;
               else
                  next_state = (state == WR) ? RD : FILLWR;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state   <= IDLE;
         src_cnt <= '0;
         dst_cnt <= '0;
         cnt     <= '0;
         hold    <= '0;
         rd_bank <= '0;
         cpu_ack <= 1'b0;
         ack_rd  <= 1'b0;
      end else begin
         state   <= next_state;
         cpu_ack <= cpu_gnt;
         ack_rd  <= cpu_gnt & ~cpu_we;
         if (acc)
            rd_bank <= acc_addr[ADDR_W-1:BANK_AW];
         // Q belongs to the DMA read even if the CPU owns this cycle
         if (state == CAP)
            hold <= q_sel;
         if (start) begin
            src_cnt <= src;
            dst_cnt <= dst;
            cnt     <= len;
         end else if (dma_wr) begin
            src_cnt <= src_cnt + 1'b1;
            dst_cnt <= dst_cnt + 1'b1;
            cnt     <= cnt - 1'b1;
         end
      end
   end

   assign q_sel     = Q[{rd_bank, 3'b000} +: 8];
   assign cpu_rdata = ack_rd ? q_sel : 8'h00;

   always_comb begin
      acc      = cpu_gnt | dma_rd | dma_wr;
      acc_we   = cpu_gnt ? cpu_we : dma_wr;
      acc_addr = dst_cnt;
      acc_data = (state == FILLWR) ? fill : hold;
      if (cpu_gnt) begin
         acc_addr = cpu_addr;
         acc_data = cpu_wdata;
      end else if (dma_rd) begin
         acc_addr = src_cnt;
      end
      CEN  = ~acc;
      A    = '0;
      WEN  = 8'hFF;
      D    = '0;
      GWEN = '1;
      if (acc)
         A = acc_addr[BANK_AW-1:0];
      if (acc & acc_we) begin
         WEN  = 8'h00;
         D    = acc_data;
         GWEN = ~(BANKS'(1) << acc_addr[ADDR_W-1:BANK_AW]);
      end
   end

endmodule

// File: tb/tb_sram_dma_ctrl.sv
// tb_sram_dma_ctrl: directed bench with a behavioural 8-bank SRAM.
module tb_sram_dma_ctrl;

   logic        clk_i = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0, cpu_rdata;
   logic        cpu_ack;
   logic [2:0]  addr = '0;
   logic [7:0]  data_in = '0, data_out;
   logic        bus_cyc = 1'b0, bus_we = 1'b0;
   logic        irq_o, CEN;
   logic [7:0]  WEN, D, GWEN;
   logic [8:0]  A;
   logic [63:0] Q;

   logic [7:0] mem [0:4095];
   logic [7:0] qreg [0:7];

   int pass = 0;
   int total = 0;

   always #5 clk_i = ~clk_i;

   sram_dma_ctrl dut (
      .clk_i(clk_i), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .addr(addr), .data_in(data_in), .data_out(data_out),
      .bus_cyc(bus_cyc), .bus_we(bus_we), .irq_o(irq_o),
      .CEN(CEN), .WEN(WEN), .A(A), .D(D), .GWEN(GWEN), .Q(Q)
   );

   for (genvar g = 0; g < 8; g++) begin : g_q
      assign Q[8*g +: 8] = qreg[g];
   end

   always @(posedge clk_i) begin
      if (!CEN) begin
         for (int b = 0; b < 8; b++) begin
            if (!GWEN[b])
               mem[{b[2:0], A}] <= D;
            else
               qreg[b] <= mem[{b[2:0], A}];
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      addr = a; data_in = d; bus_cyc = 1'b1; bus_we = 1'b1;
      tick();
      bus_cyc = 1'b0; bus_we = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = data_out;
   endtask

   task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
   endtask

   task automatic setup(input logic [11:0] s, input logic [11:0] dd,
                        input logic [11:0] l);
      bus_write(3'd0, s[7:0]);
      bus_write(3'd1, {4'h0, s[11:8]});
      bus_write(3'd2, dd[7:0]);
      bus_write(3'd3, {4'h0, dd[11:8]});
      bus_write(3'd4, l[7:0]);
      bus_write(3'd5, {4'h0, l[11:8]});
   endtask

   task automatic count_busy(output int n);
      n = 0;
      addr = 3'd6;
      #1;
      while (data_out[0] && n < 200) begin
         n++;
         tick();
         #1;
      end
   endtask

   task automatic test_reset();
      logic [7:0] st;
      repeat (3) @(posedge clk_i);
      #1 rst = 1'b0;
      #1;
      total++; if (CEN !== 1'b1) $display("FAIL rst_cen act=%b exp=1", CEN); else pass++;
      total++; if (GWEN !== 8'hFF) $display("FAIL rst_gwen act=%h exp=ff", GWEN); else pass++;
      total++; if (WEN !== 8'hFF || A !== 9'h0 || D !== 8'h0)
         $display("FAIL rst_bus act=%h/%h/%h exp=ff/000/00", WEN, A, D); else pass++;
      total++; if (irq_o !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 8'h0)
         $display("FAIL rst_out act=%b/%b/%h exp=0/0/00", irq_o, cpu_ack, cpu_rdata); else pass++;
      rd_reg(3'd6, st);
      total++; if (st !== 8'h00) $display("FAIL rst_status act=%h exp=00", st); else pass++;
   endtask

   task automatic test_cpu();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h201; cpu_wdata = 8'h5A;
      #1;
      total++; if (GWEN !== 8'hFD || WEN !== 8'h00 || A !== 9'h001 || CEN !== 1'b0)
         $display("FAIL cpu_wr_drive act=%h/%h/%h/%b exp=fd/00/001/0", GWEN, WEN, A, CEN); else pass++;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      total++; if (cpu_ack !== 1'b1) $display("FAIL cpu_wr_ack act=%b exp=1", cpu_ack); else pass++;
      tick();
      total++; if (cpu_ack !== 1'b0) $display("FAIL cpu_ack_pulse act=%b exp=0", cpu_ack); else pass++;
      cpu_req = 1'b1; cpu_addr = 12'h201;
      tick();
      cpu_req = 1'b0;
      total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A)
         $display("FAIL cpu_rd act=%b/%h exp=1/5a", cpu_ack, cpu_rdata); else pass++;
      tick();
   endtask

   task automatic test_copy();
      int n;
      logic [7:0] st;
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) cpu_write(12'h010 + 12'(i), exp[i]);
      setup(12'h010, 12'h800, 12'd4);
      bus_write(3'd6, 8'h05);
      count_busy(n);
      total++; if (n !== 12) $display("FAIL copy_busy act=%0d exp=12", n); else pass++;
      for (int i = 0; i < 4; i++) begin
         total++; if (mem[12'h800 + 12'(i)] !== exp[i])
            $display("FAIL copy_data[%0d] act=%h exp=%h", i, mem[12'h800 + 12'(i)], exp[i]); else pass++;
      end
      repeat (3) tick();
      rd_reg(3'd6, st);
      total++; if (irq_o !== 1'b1 || st !== 8'h06)
         $display("FAIL copy_irq act=%b/%h exp=1/06", irq_o, st); else pass++;
      bus_write(3'd6, 8'h14);
      rd_reg(3'd6, st);
      total++; if (irq_o !== 1'b0 || st !== 8'h04)
         $display("FAIL done_clr act=%b/%h exp=0/04", irq_o, st); else pass++;
   endtask

   task automatic test_contention();
      int n, acks;
      logic [7:0] st, rd;
      cpu_write(12'h100, 8'hA1);
      cpu_write(12'h101, 8'hA2);
      cpu_write(12'h900, 8'h00);
      cpu_write(12'h901, 8'h00);
      setup(12'h100, 12'h900, 12'd2);
      bus_write(3'd6, 8'h01);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      acks = 0; rd = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cpu_ack === 1'b1) acks++;
         rd = cpu_rdata;
      end
      cpu_req = 1'b0;
      total++; if (acks !== 10) $display("FAIL cont_acks act=%0d exp=10", acks); else pass++;
      total++; if (rd !== 8'h11) $display("FAIL cont_rdata act=%h exp=11", rd); else pass++;
      rd_reg(3'd6, st);
      total++; if (st[0] !== 1'b1 || mem[12'h900] !== 8'h00)
         $display("FAIL cont_stall act=%b/%h exp=1/00", st[0], mem[12'h900]); else pass++;
      count_busy(n);
      total++; if (n >= 200) $display("FAIL cont_timeout act=%0d exp<200", n); else pass++;
      total++; if (mem[12'h900] !== 8'hA1 || mem[12'h901] !== 8'hA2)
         $display("FAIL cont_data act=%h%h exp=a1a2", mem[12'h900], mem[12'h901]); else pass++;
   endtask

   task automatic test_wrap_len0();
      int n, cen_low;
      logic [7:0] st;
      cpu_write(12'hFFE, 8'hC1);
      cpu_write(12'hFFF, 8'hC2);
      cpu_write(12'h000, 8'hC3);
      setup(12'hFFE, 12'h400, 12'd3);
      rd_reg(3'd1, st);
      total++; if (st !== 8'h0F) $display("FAIL src_hi_rd act=%h exp=0f", st); else pass++;
      bus_write(3'd6, 8'h01);
      count_busy(n);
      total++; if (n !== 9) $display("FAIL wrap_busy act=%0d exp=9", n); else pass++;
      total++; if (mem[12'h400] !== 8'hC1 || mem[12'h401] !== 8'hC2 || mem[12'h402] !== 8'hC3)
         $display("FAIL wrap_data act=%h%h%h exp=c1c2c3", mem[12'h400], mem[12'h401], mem[12'h402]); else pass++;
      bus_write(3'd6, 8'h10);
      bus_write(3'd4, 8'h00);
      bus_write(3'd5, 8'h00);
      rd_reg(3'd6, st);
      total++; if (st !== 8'h00) $display("FAIL len0_pre act=%h exp=00", st); else pass++;
      cen_low = 0;
      addr = 3'd6; data_in = 8'h01; bus_cyc = 1'b1; bus_we = 1'b1;
      #1 if (CEN !== 1'b1) cen_low++;
      tick();
      bus_cyc = 1'b0; bus_we = 1'b0;
      rd_reg(3'd6, st);
      total++; if (st !== 8'h02) $display("FAIL len0_done act=%h exp=02", st); else pass++;
      for (int i = 0; i < 3; i++) begin
         if (CEN !== 1'b1) cen_low++;
         tick();
      end
      total++; if (cen_low !== 0) $display("FAIL len0_cen act=%0d exp=0", cen_low); else pass++;
   endtask

   task automatic test_abort();
      logic [7:0] st;
      for (int i = 0; i < 4; i++) begin
         cpu_write(12'h020 + 12'(i), 8'hD1 + 8'(i));
         cpu_write(12'hA00 + 12'(i), 8'h00);
      end
      setup(12'h020, 12'hA00, 12'd4);
      bus_write(3'd6, 8'h01);
      repeat (8) tick();
      bus_write(3'd6, 8'h08);
      rd_reg(3'd6, st);
      total++; if (st !== 8'h00) $display("FAIL abort_status act=%h exp=00", st); else pass++;
      repeat (4) tick();
      total++; if (mem[12'hA00] !== 8'hD1 || mem[12'hA01] !== 8'hD2 ||
                   mem[12'hA02] !== 8'h00 || mem[12'hA03] !== 8'h00)
         $display("FAIL abort_data act=%h%h%h%h exp=d1d20000", mem[12'hA00],
                  mem[12'hA01], mem[12'hA02], mem[12'hA03]); else pass++;
      bus_write(3'd6, 8'h09);
      rd_reg(3'd6, st);
      total++; if (st[0] !== 1'b0) $display("FAIL start_abort act=%b exp=0", st[0]); else pass++;
   endtask

   task automatic test_fill();
      logic [7:0] st;
`ifdef SRAM_DMA_FILL_EN
      int n;
      bus_write(3'd7, 8'hAA);
      setup(12'h000, 12'hB00, 12'd16);
      bus_write(3'd6, 8'h03);
      count_busy(n);
      total++; if (n !== 16) $display("FAIL fill_busy act=%0d exp=16", n); else pass++;
      for (int i = 0; i < 16; i++) begin
         total++; if (mem[12'hB00 + 12'(i)] !== 8'hAA)
            $display("FAIL fill_data[%0d] act=%h exp=aa", i, mem[12'hB00 + 12'(i)]); else pass++;
      end
`else
      bus_write(3'd7, 8'h55);
      rd_reg(3'd7, st);
      total++; if (st !== 8'h00) $display("FAIL fill_reg act=%h exp=00", st); else pass++;
      bus_write(3'd6, 8'h02);
      rd_reg(3'd6, st);
      total++; if (st[3] !== 1'b0) $display("FAIL fill_mode act=%b exp=0", st[3]); else pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_cpu();
      test_copy();
      test_contention();
      test_wrap_len0();
      test_abort();
      test_fill();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
